// File: rtl/mem_io_responder.sv
// Memory-bus responder: byte-wide RAM, UART TX FIFO with back-pressure, RX pop,
// free-running cycle counter with coherent snapshot, and the program-stop flag.
module mem_io_responder #(
   parameter int RAM_AW   = 17,
   parameter int TXF_LOG2 = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        program_done,
   output logic        tx_overflow
);

   localparam int                D         = 1 << TXF_LOG2;
   localparam logic [TXF_LOG2:0] DEPTH     = (TXF_LOG2 + 1)'(D);
   localparam logic [TXF_LOG2:0] FULL_MARK = DEPTH - 2;

   logic [7:0]          ram     [2**RAM_AW];
   logic [7:0]          txf_mem [D];

   logic [7:0]          mem_din_q, mem_din_d;
   logic [31:0]         counter_q, counter_d;
   logic [31:0]         snap_q, snap_d;
   logic [TXF_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [TXF_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [TXF_LOG2:0]   count_q, count_d;
   logic                full_q, full_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;

   logic       acc, sel_io, sel_ram, io_tx, io_stop, io_cnt;
   logic       push_req, push_ok, pop;
   logic [7:0] push_data, rd_data;
   logic       unused_addr;

   assign unused_addr = ^mem_a[31:18];

   // Only bits [17:0] take part in decode; 0x2xxxx is an unmapped hole.
   assign acc     = rdy_in && !rst_in;
   assign sel_io  = (mem_a[17:16] == 2'b11);
   assign sel_ram = !mem_a[17];
   assign io_tx   = sel_io && (mem_a[15:0] == 16'h0000);
   assign io_stop = sel_io && (mem_a[15:0] == 16'h0004);
   assign io_cnt  = sel_io && (mem_a[15:2] == 14'h0001);

   assign push_req  = acc && mem_wr && ((io_tx && mem_dout != 8'h00) || io_stop);
   assign push_data = io_stop ? 8'h00 : mem_dout;
   assign pop       = tx_valid && tx_ready;
   assign push_ok   = push_req && (count_q != DEPTH || pop);

   assign rx_ready = acc && !mem_wr && io_tx && rx_valid;

   assign tx_valid       = (count_q != '0);
   assign tx_data        = tx_valid ? txf_mem[rd_ptr_q] : 8'h00;
   assign mem_din        = mem_din_q;
   assign io_buffer_full = full_q;
   assign program_done   = done_q;
   assign tx_overflow    = ovf_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      rd_data = 8'h00;
      if (sel_ram) begin
         rd_data = ram[mem_a[RAM_AW-1:0]];
      end else if (io_tx) begin
         rd_data = rx_valid ? rx_data : 8'h00;
      end else if (io_cnt) begin
         case (mem_a[1:0])
            2'd0:    rd_data = counter_q[7:0];
            2'd1:    rd_data = snap_q[15:8];
            2'd2:    rd_data = snap_q[23:16];
            default: rd_data = snap_q[31:24];
         endcase
      end
   end

   always_comb begin
      mem_din_d = mem_din_q;
      counter_d = counter_q;
      snap_d    = snap_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;

      if (acc) begin
         counter_d = counter_q + 32'd1;
         if (!mem_wr) begin
            mem_din_d = rd_data;
            if (io_cnt && mem_a[1:0] == 2'd0) snap_d = counter_q;
         end
         if (mem_wr && io_stop) done_d = 1'b1;
      end

      if (push_req && !push_ok) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (TXF_LOG2 + 1)'(push_ok) - (TXF_LOG2 + 1)'(pop);
      // Two-entry margin absorbs stores already in flight in the CPU pipeline.
      full_d  = (count_d >= FULL_MARK);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_din_q <= 8'h00;
         counter_q <= '0;
         snap_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         mem_din_q <= mem_din_d;
         counter_q <= counter_d;
         snap_q    <= snap_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   // NOTE: storage arrays are never reset; only pointers and flags are.
   always_ff @(posedge clk_in) begin
      if (acc && mem_wr && sel_ram) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      if (push_ok) txf_mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX FIFO, counter,
// stop flag, RX pop, stall and mid-run reset.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        program_done;
   logic        tx_overflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] uart_q[$];

   mem_io_responder dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .mem_a         (mem_a),
      .mem_wr        (mem_wr),
      .mem_dout      (mem_dout),
      .mem_din       (mem_din),
      .io_buffer_full(io_buffer_full),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .program_done  (program_done),
      .tx_overflow   (tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // UART side: every byte handed over in a cycle is recorded mid-cycle.
   always @(negedge clk_in) begin
      if (tx_valid && tx_ready) uart_q.push_back(tx_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
      rdy_in   = rdy;
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_din"},  {24'h0, mem_din}, 32'h0);
      check({tag, "_full"}, {31'h0, io_buffer_full}, 32'h0);
      check({tag, "_txv"},  {31'h0, tx_valid}, 32'h0);
      check({tag, "_txd"},  {24'h0, tx_data}, 32'h0);
      check({tag, "_rxr"},  {31'h0, rx_ready}, 32'h0);
      check({tag, "_done"}, {31'h0, program_done}, 32'h0);
      check({tag, "_ovf"},  {31'h0, tx_overflow}, 32'h0);
   endtask

   initial begin
      rst_in   = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      tick();
      tick();
      check_reset_outputs("reset");
      rst_in = 1'b0;

      // Counter coherence: 255 counted cycles put the counter at 0x000000FF.
      bus(1'b1, 32'h0002_0000, 1'b0, 8'h00);
      for (int i = 0; i < 255; i++) tick();
      check("unmapped_rd", {24'h0, mem_din}, 32'h0);
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("cnt_b0", {24'h0, mem_din}, 32'hFF);
      bus(1'b1, 32'h0003_0005, 1'b0, 8'h00); tick();
      check("cnt_b1", {24'h0, mem_din}, 32'h00);
      bus(1'b1, 32'h0003_0006, 1'b0, 8'h00); tick();
      check("cnt_b2", {24'h0, mem_din}, 32'h00);
      bus(1'b1, 32'h0003_0007, 1'b0, 8'h00); tick();
      check("cnt_b3", {24'h0, mem_din}, 32'h00);

      // Wrap: park the counter at all-ones while the bus is idle.
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      force dut.counter_q = 32'hFFFF_FFFF;
      #1;
      release dut.counter_q;
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("wrap_b0", {24'h0, mem_din}, 32'hFF);
      bus(1'b1, 32'h0003_0007, 1'b0, 8'h00); tick();
      check("wrap_snap_b3", {24'h0, mem_din}, 32'hFF);
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("wrap_after_b0", {24'h0, mem_din}, 32'h01);
      bus(1'b1, 32'h0003_0007, 1'b0, 8'h00); tick();
      check("wrap_after_b3", {24'h0, mem_din}, 32'h00);

      // Stall: write to TX with rdy low does nothing, counter frozen at 3.
      bus(1'b0, 32'h0003_0000, 1'b1, 8'h55);
      for (int i = 0; i < 3; i++) tick();
      check("stall_no_push", {31'h0, tx_valid}, 32'h0);
      check("stall_din_hold", {24'h0, mem_din}, 32'h00);
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("stall_cnt", {24'h0, mem_din}, 32'h03);

      // RAM write then read.
      bus(1'b1, 32'h0000_0010, 1'b1, 8'h5A); tick();
      bus(1'b1, 32'h0001_FFFF, 1'b1, 8'hC3); tick();
      bus(1'b1, 32'h0000_0010, 1'b0, 8'h00); tick();
      check("ram_rd_10", {24'h0, mem_din}, 32'h5A);
      bus(1'b1, 32'h0002_0000, 1'b0, 8'h00); tick();
      check("ram_rd_20000", {24'h0, mem_din}, 32'h00);
      bus(1'b1, 32'h0001_FFFF, 1'b0, 8'h00); tick();
      check("ram_rd_1ffff", {24'h0, mem_din}, 32'hC3);

      // TX path: 0x00 data writes are not pushed.
      uart_q.delete();
      tx_ready = 1'b1;
      bus(1'b1, 32'h0003_0000, 1'b1, 8'h41); tick();
      check("tx_head_41", {24'h0, tx_data}, 32'h41);
      bus(1'b1, 32'h0003_0000, 1'b1, 8'h00); tick();
      bus(1'b1, 32'h0003_0000, 1'b1, 8'h42); tick();
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) tick();
      check("tx_count", uart_q.size(), 32'd2);
      if (uart_q.size() == 2) begin
         check("tx_byte0", {24'h0, uart_q[0]}, 32'h41);
         check("tx_byte1", {24'h0, uart_q[1]}, 32'h42);
      end

      // Back-pressure: 17 pushes into a stalled UART.
      uart_q.delete();
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus(1'b1, 32'h0003_0000, 1'b1, 8'h10 + 8'(i)); tick();
         if (i == 12) check("bp_full_at13", {31'h0, io_buffer_full}, 32'h0);
         if (i == 13) check("bp_full_at14", {31'h0, io_buffer_full}, 32'h1);
         if (i == 15) check("bp_ovf_at16", {31'h0, tx_overflow}, 32'h0);
         if (i == 16) check("bp_ovf_at17", {31'h0, tx_overflow}, 32'h1);
      end
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("drain_count", uart_q.size(), 32'd16);
      if (uart_q.size() == 16) begin
         for (int i = 0; i < 16; i++) check("drain_byte", {24'h0, uart_q[i]}, 32'h10 + i);
      end
      check("drain_empty", {31'h0, tx_valid}, 32'h0);
      check("drain_full_low", {31'h0, io_buffer_full}, 32'h0);
      check("ovf_sticky", {31'h0, tx_overflow}, 32'h1);

      // Stop: terminator 0x00 is pushed even though data 0x00 normally is not.
      tx_ready = 1'b0;
      bus(1'b1, 32'h0003_0004, 1'b1, 8'h77); tick();
      check("stop_done", {31'h0, program_done}, 32'h1);
      check("stop_txv", {31'h0, tx_valid}, 32'h1);
      check("stop_txd", {24'h0, tx_data}, 32'h00);
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      tx_ready = 1'b1;
      tick();
      check("stop_drained", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      // RX pop.
      rx_valid = 1'b1;
      rx_data  = 8'h33;
      bus(1'b0, 32'h0003_0000, 1'b0, 8'h00);
      #1;
      check("rx_stall_no_pop", {31'h0, rx_ready}, 32'h0);
      bus(1'b1, 32'h0003_0000, 1'b0, 8'h00);
      #1;
      check("rx_ready_pulse", {31'h0, rx_ready}, 32'h1);
      tick();
      check("rx_data", {24'h0, mem_din}, 32'h33);
      bus(1'b0, 32'h0, 1'b0, 8'h00);
      #1;
      check("rx_ready_drop", {31'h0, rx_ready}, 32'h0);
      rx_valid = 1'b0;
      bus(1'b1, 32'h0003_0000, 1'b0, 8'h00);
      #1;
      check("rx_empty_no_pop", {31'h0, rx_ready}, 32'h0);
      tick();
      check("rx_empty_data", {24'h0, mem_din}, 32'h00);

      // Mid-run reset with FIFO half full and read data pending.
      for (int i = 0; i < 8; i++) begin
         bus(1'b1, 32'h0003_0000, 1'b1, 8'h61 + 8'(i)); tick();
      end
      bus(1'b1, 32'h0000_0010, 1'b0, 8'h00); tick();
      check("pre_rst_din", {24'h0, mem_din}, 32'h5A);
      check("pre_rst_txv", {31'h0, tx_valid}, 32'h1);
      rx_valid = 1'b1;
      rst_in   = 1'b1;
      bus(1'b1, 32'h0003_0000, 1'b0, 8'h00);
      tick();
      check_reset_outputs("midrst");
      rst_in   = 1'b0;
      rx_valid = 1'b0;
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("post_rst_cnt0", {24'h0, mem_din}, 32'h00);
      bus(1'b1, 32'h0003_0004, 1'b0, 8'h00); tick();
      check("post_rst_cnt1", {24'h0, mem_din}, 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation timeout");
   end

endmodule
